// File: rtl/fd_reg_pingpong.sv
// Double-buffered FAST candidate register file: loader fills bank wb while the core reads bank rb.
// Each set is a reference pixel plus N_ADJ circle pixels, with a threshold latched when the set closes.
module fd_reg_pingpong #(
  parameter int PIX_W         = 8,
  parameter int N_ADJ         = 16,
  parameter int ADDR_W        = 5,
  parameter int THRES_DEFAULT = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wrEn,
  input  logic [ADDR_W-1:0]      regAddr,
  input  logic [PIX_W-1:0]       sramData,
  input  logic                   loadDone,
  input  logic                   thresWe,
  input  logic [PIX_W-1:0]       thresIn,
  output logic                   loadReady,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [PIX_W-1:0]       refPixel,
  output logic [N_ADJ*PIX_W-1:0] adjPixel,
  output logic [PIX_W-1:0]       thres,
  output logic [1:0]             bankCount,
  output logic                   loadErr
);

  localparam int                N_ENT    = N_ADJ + 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(N_ADJ);
  localparam logic [PIX_W-1:0]  THR_RST  = PIX_W'(THRES_DEFAULT);

  logic [PIX_W-1:0] pix [2][N_ENT];
  logic [N_ADJ:0]   mask [2];
  logic [PIX_W-1:0] thr_bank [2];
  logic [PIX_W-1:0] thr_pend;
  logic [1:0]       full;
  logic             wb;
  logic             rb;
  logic             err;

  logic             addr_ok;
  logic             wr_ok;
  logic [N_ADJ:0]   wr_bit;
  logic [N_ADJ:0]   mask_next;
  logic             close_ok;
  logic             consume;
  logic [PIX_W-1:0] thr_cap;
  logic             proto_err;

  assign loadReady = ~full[wb];
  assign outValid  = full[rb];
  assign bankCount = {1'b0, full[0]} + {1'b0, full[1]};
  assign loadErr   = err;

  assign addr_ok   = (regAddr <= MAX_ADDR);
  assign wr_ok     = wrEn && loadReady && addr_ok;
  assign wr_bit    = wr_ok ? (N_ENT'(1) << regAddr) : '0;
  // A write landing in the same cycle as loadDone counts toward completeness.
  assign mask_next = mask[wb] | wr_bit;
  assign close_ok  = loadDone && loadReady && (&mask_next);
  assign consume   = outValid && outReady;
  assign thr_cap   = thresWe ? thresIn : thr_pend;
  assign proto_err = (wrEn && !(loadReady && addr_ok)) || (loadDone && !close_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < N_ENT; e++) pix[b][e] <= '0;
        mask[b]     <= '0;
        thr_bank[b] <= THR_RST;
      end
      thr_pend <= THR_RST;
      full     <= 2'b00;
      wb       <= 1'b0;
      rb       <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (wr_ok) pix[wb][regAddr] <= sramData;

      if (close_ok) begin
        full[wb]     <= 1'b1;
        mask[wb]     <= '0;
        thr_bank[wb] <= thr_cap;
        wb           <= ~wb;
      end else if (wr_ok) begin
        mask[wb] <= mask_next;
      end

      // close needs full[wb]==0 and consume needs full[rb]==1, so they never hit the same bank
      if (consume) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end

      if (thresWe)   thr_pend <= thresIn;
      if (proto_err) err      <= 1'b1;
    end
  end

  always_comb begin
    refPixel = '0;
    adjPixel = '0;
    thres    = '0;
    if (outValid) begin
      refPixel = pix[rb][0];
      thres    = thr_bank[rb];
      for (int k = 1; k <= N_ADJ; k++) adjPixel[(N_ADJ-k)*PIX_W +: PIX_W] = pix[rb][k];
    end
  end

endmodule

// File: doc/fd_reg_pingpong.md
Name: fd_reg_pingpong

Overview:
- Parametrised, double-buffered successor to the FAST9 pixel register file.
- Holds two complete candidate sets, ping and pong. Each set is one reference pixel plus N_ADJ circle pixels.
- SRAM-side logic fills one bank while the detector core evaluates the other.
- Adds a per-set programmable threshold, a valid/ready output handshake, fill-completeness tracking and a sticky error flag.

Parameters:
PIX_W, 8, pixel and threshold bit width
N_ADJ, 16, circle pixels per candidate set
ADDR_W, 5, regAddr width; must satisfy 2^ADDR_W > N_ADJ
THRES_DEFAULT, 30, threshold value after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
wrEn  in  1  write sramData into the write bank entry at regAddr
regAddr  in  ADDR_W  entry select: 0 = reference pixel, k = circle pixel k (1..N_ADJ)
sramData  in  PIX_W  pixel data from SRAM
loadDone  in  1  close the current write bank (set complete)
thresWe  in  1  update the pending threshold register
thresIn  in  PIX_W  new threshold value
loadReady  out  1  write bank can accept writes
outValid  out  1  read bank holds a complete set
outReady  in  1  core consumes the presented set
refPixel  out  PIX_W  reference pixel of the read bank
adjPixel  out  N_ADJ*PIX_W  circle pixels; pixel 1 in the MSBs, pixel N_ADJ in the LSBs
thres  out  PIX_W  threshold captured with the presented set
bankCount  out  2  number of FULL banks, 0..2
loadErr  out  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous and active-high. It wins over every other input in the same cycle.
- Reset values:
  - wb = 0, rb = 0, both banks EMPTY.
  - All pixel registers and per-bank written-masks = 0.
  - Pending threshold = THRES_DEFAULT; per-bank threshold copies = THRES_DEFAULT.
  - outValid = 0, loadReady = 1, bankCount = 0, loadErr = 0.
  - refPixel, adjPixel and thres read 0.
  - Reset mid-fill or mid-handshake discards all stored sets.
- Per-bank state: EMPTY (mask all 0), FILLING (mask nonzero, not FULL), FULL (closed by loadDone).
- Write path:
  - A write occurs when wrEn && loadReady && regAddr <= N_ADJ.
  - The entry is written at the clock edge and its mask bit is set.
  - Rewriting the same entry overwrites it; the newest data wins.
  - wrEn && !loadReady: write dropped, loadErr set.
  - wrEn with regAddr > N_ADJ: write dropped, loadErr set.
- Close path:
  - loadDone is accepted only if the write bank's mask is all-ones after including any same-cycle write.
  - A same-cycle wrEn + loadDone counts the write as part of the set.
  - On acceptance, in the same cycle:
    - the write bank becomes FULL;
    - the pending threshold is copied into the bank's threshold copy;
    - the write bank's mask is cleared for reuse;
    - wb toggles.
  - loadDone on an incomplete bank, or while !loadReady: ignored, loadErr set, bank contents kept.
- Threshold path:
  - thresWe loads thresIn into the pending threshold register.
  - Bank copies change only when a set is closed, so thres always matches the presented set.
  - thresWe in the same cycle as loadDone: the bank captures the new thresIn value.
- Read path:
  - outValid = read bank FULL.
  - When outValid, refPixel, adjPixel and thres come from bank rb; when !outValid they read 0.
  - outValid && outReady at an edge: bank rb becomes EMPTY and rb toggles.
  - outReady while !outValid has no effect and no error.
- Handshake rules:
  - loadReady = write bank not FULL.
  - Outputs are stable while outValid && !outReady.
- Latency:
  - loadDone accepted at edge t with the read bank previously empty: outValid = 1 after edge t.
  - Back-to-back sets: the core can consume one set per cycle while the loader alternates banks.
- Simultaneous close and consume: both take effect in the same cycle; bankCount stays unchanged.
- bankCount increments on an accepted close, decrements on a consume, and never wraps.
- Both banks FULL: loadReady = 0 until a consume occurs; the freed bank is writable on the next cycle.
- loadErr clears only on reset.

Test Plan:
- Reset, write addresses 0..16 with data 0x10..0x20, then loadDone → next cycle:
  - outValid = 1, refPixel = 0x10;
  - adjPixel[127:120] = 0x11, adjPixel[7:0] = 0x20;
  - thres = 30, bankCount = 1, loadErr = 0.
- Write only addresses 0..15, then loadDone → outValid stays 0, loadErr = 1. Then write address 16 and loadDone → outValid = 1.
- With outReady held 0, fill two sets (A: refPixel 0xAA, B: refPixel 0xBB):
  - bankCount = 2, loadReady = 0.
  - A further wrEn sets loadErr and B is unchanged.
  - Pulse outReady → B presented (refPixel 0xBB) and loadReady = 1.
- Drive thresWe = 1 with thresIn = 50 between closing set A and closing set B → A presents thres = 30, B presents thres = 50.
- Loader closes a set on the same cycle the core consumes one, repeated 8 times:
  - bankCount constant at 1;
  - sets emerge in order with no drops.
- Assert reset in the middle of filling bank 1 with bank 0 FULL → next cycle outValid = 0, bankCount = 0, loadReady = 1, thres output 0, pending threshold back to 30.
